// File: rtl/rot_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rot_pipe
// Purpose  : Pipelined log-stage rotator / shifter with a valid/ready stream
//            interface and a sideband tag that travels with each word.
//            LOG2_N mux stages; stage s moves the word by N >> (s+1) places
//            when in_k[s] is set. A register slice follows every REG_EVERY
//            stages and always follows the last one.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            in_valid/in_ready     - input handshake
//            in_bits [0:N-1]       - data word, index 0 is the MSB
//            in_k [0:LOG2_N-1]     - shift amount, in_k[0] is the MSB
//            in_dir                - 0 = toward higher index, 1 = lower index
//            in_mode               - 0 rotate, 1 logical, 2 arithmetic, 3 rotate
//            in_tag                - sideband tag, passed through unchanged
//            out_valid/out_ready   - output handshake
//            out_bits, out_tag     - result word and its tag
// Revision : 1.0 - initial release
// ============================================================================
module rot_pipe #(
  parameter int N         = 512,
  parameter int LOG2_N    = 9,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:N-1]      in_bits,
  input  logic [0:LOG2_N-1] in_k,
  input  logic              in_dir,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:N-1]      out_bits,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int SLICES = (LOG2_N + REG_EVERY - 1) / REG_EVERY;

  // Single global advance: every slice moves together or all hold.
  logic w_adv;
  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  // One mux stage. In this bit ordering a numeric '>>' moves bits toward
  // higher indices (right), '<<' toward lower indices (left).
  function automatic logic [0:N-1] stage_op(
    input logic [0:N-1] d,
    input int           amt,
    input logic         dir,
    input logic [1:0]   mode,
    input logic         sign
  );
    logic [0:N-1] ones;
    logic [0:N-1] r;
    ones = '1;
    if (!dir) begin
      case (mode)
        2'd1:    r = d >> amt;
        // Vacated low indices take the sign bit captured at the input.
        2'd2:    r = (d >> amt) | (sign ? ~(ones >> amt) : '0);
        default: r = (d >> amt) | (d << (N - amt));
      endcase
    end else begin
      case (mode)
        2'd1, 2'd2: r = d << amt;
        default:    r = (d << amt) | (d >> (N - amt));
      endcase
    end
    return r;
  endfunction

  for (genvar j = 0; j < SLICES; j++) begin : g_slice
    localparam int FIRST  = j * REG_EVERY;
    localparam int NEXT   = ((j + 1) * REG_EVERY < LOG2_N) ? (j + 1) * REG_EVERY : LOG2_N;
    localparam int STAGES = NEXT - FIRST;

    // Inputs to this slice's stages. k keeps absolute bit indices so each
    // stage picks its own control bit directly; consumed bits are dropped.
    logic [0:N-1]          w_src_data;
    logic [FIRST:LOG2_N-1] w_src_k;
    logic                  w_src_valid;
    logic                  w_src_dir;
    logic [1:0]            w_src_mode;
    logic                  w_src_sign;
    logic [TAG_W-1:0]      w_src_tag;

    if (j == 0) begin : g_head
      assign w_src_data  = in_bits;
      assign w_src_k     = in_k;
      assign w_src_valid = in_valid & w_adv;
      assign w_src_dir   = in_dir;
      assign w_src_mode  = in_mode;
      assign w_src_sign  = in_bits[0];
      assign w_src_tag   = in_tag;
    end else begin : g_body
      assign w_src_data  = g_slice[j-1].data_q;
      assign w_src_k     = g_slice[j-1].g_side.k_q;
      assign w_src_valid = g_slice[j-1].valid_q;
      assign w_src_dir   = g_slice[j-1].g_side.dir_q;
      assign w_src_mode  = g_slice[j-1].g_side.mode_q;
      assign w_src_sign  = g_slice[j-1].g_side.sign_q;
      assign w_src_tag   = g_slice[j-1].tag_q;
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
      localparam int S = FIRST + g;
      logic [0:N-1] w_in;
      logic [0:N-1] w_out;
      if (g == 0) begin : g_src
        assign w_in = w_src_data;
      end else begin : g_link
        assign w_in = g_stage[g-1].w_out;
      end
      assign w_out = w_src_k[S]
                     ? stage_op(w_in, N >> (S + 1), w_src_dir, w_src_mode, w_src_sign)
                     : w_in;
    end

    logic               valid_d, valid_q;
    logic [0:N-1]       data_d,  data_q;
    logic [TAG_W-1:0]   tag_d,   tag_q;

    assign valid_d = w_src_valid;
    assign data_d  = g_stage[STAGES-1].w_out;
    assign tag_d   = w_src_tag;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
      end else if (w_adv) begin
        valid_q <= valid_d;
        data_q  <= data_d;
        tag_q   <= tag_d;
      end
    end

    // Control sideband is only needed where further stages remain.
    if (j < SLICES - 1) begin : g_side
      logic [NEXT:LOG2_N-1] k_d,    k_q;
      logic                 dir_d,  dir_q;
      logic [1:0]           mode_d, mode_q;
      logic                 sign_d, sign_q;

      assign k_d    = w_src_k[NEXT:LOG2_N-1];
      assign dir_d  = w_src_dir;
      assign mode_d = w_src_mode;
      assign sign_d = w_src_sign;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          k_q    <= '0;
          dir_q  <= 1'b0;
          mode_q <= 2'd0;
          sign_q <= 1'b0;
        end else if (w_adv) begin
          k_q    <= k_d;
          dir_q  <= dir_d;
          mode_q <= mode_d;
          sign_q <= sign_d;
        end
      end
    end
  end

  assign out_valid = g_slice[SLICES-1].valid_q;
  assign out_bits  = g_slice[SLICES-1].data_q;
  assign out_tag   = g_slice[SLICES-1].tag_q;

endmodule
`default_nettype wire
